// File: rtl/priority_decoder_if.sv
// rtl/priority_decoder_if.sv - code-in / one-hot-line-out signal bundle for priority_decoder.
// The decode_count member exists only when DECODE_COUNT_EN is defined.
interface priority_decoder_if;
    logic       code_valid;
    logic [1:0] code;
    logic       code_ready;
    logic [3:0] line;
    logic       line_valid;
    logic       busy;
`ifdef DECODE_COUNT_EN
    logic [7:0] decode_count;

    modport master (
        output code_valid, code,
        input  code_ready, line, line_valid, busy, decode_count
    );
    modport slave (
        input  code_valid, code,
        output code_ready, line, line_valid, busy, decode_count
    );
`else
    modport master (
        output code_valid, code,
        input  code_ready, line, line_valid, busy
    );
    modport slave (
        input  code_valid, code,
        output code_ready, line, line_valid, busy
    );
`endif
endinterface

// File: rtl/priority_decoder.sv
// rtl/priority_decoder.sv - 2-to-4 decoder holding each decoded line for HOLD_CYCLES then one gap cycle.
// Optional DECODE_COUNT_EN adds a saturating 8-bit count of accepted codes.
module priority_decoder #(
    parameter int HOLD_CYCLES = 3
) (
    input  logic               clk,
    input  logic               reset,
    priority_decoder_if.slave  bus
);
    // 0 behaves as 1; values beyond the 4-bit counter range are clamped
    localparam int HOLD_EFF = (HOLD_CYCLES < 1) ? 1 : ((HOLD_CYCLES > 15) ? 15 : HOLD_CYCLES);
    localparam logic [3:0] HOLD_LOAD = 4'(HOLD_EFF - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        GAP   = 2'd2
    } state_t;

    state_t     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic [3:0] line_q, line_d;
    logic       line_valid_q, line_valid_d;
    logic       busy_q, busy_d;
    logic       ready_q, ready_d;
    logic       xfer;

    assign xfer = ready_q && bus.code_valid;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        line_d       = line_q;
        line_valid_d = 1'b0;
        busy_d       = 1'b0;
        ready_d      = 1'b0;
        case (state_q)
            IDLE: begin
                if (xfer) begin
                    line_d  = 4'b0001 << bus.code;
                    cnt_d   = HOLD_LOAD;
                    state_d = DRIVE;
                end
            end
            DRIVE: begin
                if (cnt_q == 4'd0) begin
                    state_d = GAP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            GAP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = 4'd0;
            end
        endcase
        // Outputs are registered from the next state so they line up with it
        if (state_d != DRIVE) begin
            line_d = 4'b0000;
        end
        line_valid_d = (state_d == DRIVE);
        busy_d       = (state_d != IDLE);
        ready_d      = (state_d == IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            cnt_q        <= 4'd0;
            line_q       <= 4'b0000;
            line_valid_q <= 1'b0;
            busy_q       <= 1'b0;
            ready_q      <= 1'b1;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            line_q       <= line_d;
            line_valid_q <= line_valid_d;
            busy_q       <= busy_d;
            ready_q      <= ready_d;
        end
    end

    assign bus.code_ready = ready_q;
    assign bus.line       = line_q;
    assign bus.line_valid = line_valid_q;
    assign bus.busy       = busy_q;

`ifdef DECODE_COUNT_EN
    logic [7:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (xfer && (count_q != 8'hFF)) begin
            count_d = count_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= 8'd0;
        end else begin
            count_q <= count_d;
        end
    end

    assign bus.decode_count = count_q;
`endif
endmodule

// File: tb/tb_priority_decoder.sv
// tb/tb_priority_decoder.sv - randomized and directed checks of priority_decoder against a timeline model.
module tb_priority_decoder;
    localparam int H    = 3;
    localparam int FAR  = 1000;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    priority_decoder_if dif ();

    priority_decoder #(.HOLD_CYCLES(H)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (dif.slave)
    );

    int         total = 0;
    int         bad   = 0;
    int         since = FAR;
    logic [1:0] mcode = 2'b00;
    int         mcount = 0;
    int         rises;
    logic       prev_lv;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Model: "since" counts edges since the last accepted code; everything follows from it
    task automatic tick(input logic v, input logic [1:0] c, input logic r);
        logic [31:0] exp_line;
        dif.code_valid = v;
        dif.code       = c;
        reset          = r;
        @(posedge clk);
        if (r) begin
            since  = FAR;
            mcount = 0;
        end else if (since > H + 1 && v) begin
            since  = 1;
            mcode  = c;
            mcount = (mcount < 255) ? mcount + 1 : 255;
        end else if (since < FAR) begin
            since++;
        end
        #1;
        exp_line = (since >= 1 && since <= H) ? (32'd1 << mcode) : 32'd0;
        check("line",       32'(dif.line),       exp_line);
        check("line_valid", 32'(dif.line_valid), 32'(since >= 1 && since <= H));
        check("busy",       32'(dif.busy),       32'(since >= 1 && since <= H + 1));
        check("code_ready", 32'(dif.code_ready), 32'(since > H + 1));
        check("onehot",     32'($countones(dif.line) <= 1), 32'd1);
`ifdef DECODE_COUNT_EN
        check("decode_count", 32'(dif.decode_count), 32'(mcount));
`endif
    endtask

    initial begin
        dif.code_valid = 1'b0;
        dif.code       = 2'b00;
        reset          = 1'b1;

        tick(1'b1, 2'b11, 1'b1);
        tick(1'b1, 2'b10, 1'b1);

        // single code 01 with gap and re-ready
        tick(1'b1, 2'b01, 1'b0);
        repeat (5) tick(1'b0, 2'b00, 1'b0);

        // sweep all codes with noisy inputs while busy
        for (int c = 0; c < 4; c++) begin
            tick(1'b1, 2'(c), 1'b0);
            repeat (H + 1) tick(1'($urandom), 2'($urandom), 1'b0);
        end

        // continuous valid: one transfer every H+2 cycles
        rises   = 0;
        prev_lv = 1'b0;
        repeat (25) begin
            tick(1'b1, 2'b11, 1'b0);
            if (dif.line_valid && !prev_lv) rises++;
            prev_lv = dif.line_valid;
        end
        check("xfer_spacing", 32'(rises), 32'd5);
        repeat (5) tick(1'b0, 2'b00, 1'b0);

        // code change during DRIVE must not alter line
        tick(1'b1, 2'b10, 1'b0);
        repeat (H + 1) tick(1'b1, 2'b00, 1'b0);
        repeat (2) tick(1'b0, 2'b00, 1'b0);

        // reset in second DRIVE cycle
        tick(1'b1, 2'b01, 1'b0);
        tick(1'b0, 2'b00, 1'b1);
        tick(1'b0, 2'b00, 1'b0);

        // reset during GAP
        tick(1'b1, 2'b10, 1'b0);
        repeat (H) tick(1'b0, 2'b00, 1'b0);
        tick(1'b1, 2'b11, 1'b1);
        tick(1'b0, 2'b00, 1'b0);

        // random traffic with occasional reset
        repeat (400) tick(1'($urandom_range(0, 3) != 0), 2'($urandom), 1'($urandom_range(0, 49) == 0));

`ifdef DECODE_COUNT_EN
        tick(1'b0, 2'b00, 1'b1);
        repeat (1600) tick(1'b1, 2'($urandom), 1'b0);
        check("count_sat", 32'(dif.decode_count), 32'hFF);
        tick(1'b0, 2'b00, 1'b1);
        check("count_rst", 32'(dif.decode_count), 32'h0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/priority_decoder.md
PRIORITY_DECODER -- requirements
Module: priority_decoder

Interface
REQ-001 Parameter HOLD_CYCLES, default 3, number of cycles a decoded line is held asserted (legal 1..15; 0 SHALL behave as 1).
REQ-002 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 code_valid  input  1  a 2-bit code is offered this cycle.
REQ-005 code  input  2  code[1]=W, code[0]=Y; priority code from the 4-input encoder.
REQ-006 code_ready  output  1  block can accept a code this cycle.
REQ-007 line  output  4  one-hot decoded line, order {A,B,C,D} = line[3:0].
REQ-008 line_valid  output  1  line carries a decoded value.
REQ-009 busy  output  1  block is in DRIVE or GAP.

Function
REQ-010 Mapping SHALL be code 2'b11->line 4'b1000 (A), 2'b10->4'b0100 (B), 2'b01->4'b0010 (C), 2'b00->4'b0001 (D), i.e. line[code]=1, all other bits 0.
REQ-011 FSM states SHALL be IDLE, DRIVE, GAP; all outputs SHALL be registered.
REQ-012 code_ready SHALL be 1 only in IDLE; a transfer occurs on a rising edge where code_valid=1 and code_ready=1.
REQ-013 IDLE: on transfer, register the decoded line, load hold counter with HOLD_CYCLES-1, go to DRIVE; otherwise stay.
REQ-014 Latency: line/line_valid SHALL be asserted in the cycle immediately after the transfer edge.
REQ-015 DRIVE: line_valid=1, line constant, busy=1; counter decrements each cycle; when counter=0, go to GAP.
REQ-016 line_valid SHALL be high for exactly HOLD_CYCLES consecutive cycles per accepted code.
REQ-017 GAP: exactly one cycle with line=4'b0000, line_valid=0, busy=1, code_ready=0; then IDLE.
REQ-018 code_valid or code changes during DRIVE/GAP SHALL be ignored and SHALL NOT alter line.
REQ-019 Minimum spacing between transfers SHALL be HOLD_CYCLES+2 cycles.
REQ-020 Outside DRIVE, line SHALL be 4'b0000 and line_valid 0; line SHALL never have more than one bit set.
REQ-021 Hold counter SHALL be 4 bits and SHALL NOT wrap below 0.

Reset
REQ-022 reset=1 at a rising edge SHALL force IDLE, line=4'b0000, line_valid=0, busy=0, counter=0, overriding any transfer in the same cycle.
REQ-023 In the cycle after reset deasserts, code_ready SHALL be 1.
REQ-024 Reset asserted mid-DRIVE or mid-GAP SHALL abort the operation with no residual GAP cycle.

Configuration
REQ-025 Macro DECODE_COUNT_EN, when defined, SHALL add output decode_count (8 bits), reset to 0, incremented on each transfer, saturating at 8'hFF.
REQ-026 Without DECODE_COUNT_EN, the decode_count port and its logic SHALL be absent; all other behaviour SHALL be identical.

Verification
REQ-027 Reset 2 cycles, then code=2'b01 with code_valid for 1 cycle (HOLD_CYCLES=3) -> line=4'b0010, line_valid=1 for 3 cycles starting next cycle, then 1 GAP cycle of 0000, code_ready=1 again after.
REQ-028 Sweep codes 00,01,10,11, each after code_ready -> lines 0001, 0010, 0100, 1000 respectively, one-hot every cycle.
REQ-029 Hold code_valid=1 continuously with code=2'b11 -> transfers exactly every 5 cycles, line=4'b1000 never overlapping GAP.
REQ-030 Change code to 2'b00 during DRIVE of code 2'b10 -> line stays 4'b0100 until GAP.
REQ-031 Assert reset in second DRIVE cycle -> next cycle line=0000, line_valid=0, busy=0, code_ready=1 after deassert.
REQ-032 With DECODE_COUNT_EN, 300 transfers -> decode_count=8'hFF; reset -> decode_count=0.
